bcd_serial_add_ctrl: RTL
========================

// Module: bcd_serial_add_ctrl
// PURPOSE
//   Sequencer that adds two NDIG-digit packed-BCD operands by time-sharing one
//   2-digit (8-bit) BCD adder stage, one digit pair per cycle, LSB byte first.
//   The carry between bytes is held in a register. Sits between a
//   valid/ready operand source and a valid/ready result sink. It is the
//   multi-digit front end for the 8-bit BCD adder datapath.
// PARAMETERS
//   NDIG   8   operand width in BCD digits; even, >=2; NBYTE = NDIG/2
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand pair present
//   in_ready   out  1        block can accept operands (IDLE only)
//   in_a       in   4*NDIG   packed BCD operand A, digit 0 in [3:0]
//   in_b       in   4*NDIG   packed BCD operand B
//   in_cin     in   1        carry-in to digit 0
//   out_valid  out  1        result held and valid
//   out_ready  in   1        sink accepts result
//   out_sum    out  4*NDIG   packed BCD sum
//   out_cout   out  1        decimal carry out of the top digit
//   out_err    out  1        some input digit of A or B was >9; out_sum undefined
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0,
//   out_err=0, busy=0, idx=0, carry reg=0.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. When in_valid&in_ready, latch A, B, and carry<=in_cin.
//     Set idx<=0 and err<=(any nibble of A or B >4'd9). Clear result reg. Go to RUN.
//   - RUN: in_ready=0. The byte adder sees A[idx], B[idx], and carry. It writes
//     the sum byte to result[idx], then carry<=adder Cout. If idx==NBYTE-1, go
//     to DONE. Otherwise idx<=idx+1.
//   - DONE: out_valid=1. out_sum, out_cout (=final carry), and out_err are
//     stable and must not change. On out_ready, go to IDLE and drop out_valid.
//     in_ready stays 0 in the cycle of the handoff, so a new accept is possible
//     at the earliest one cycle later.
//   Latency: accept edge at cycle T -> out_valid=1 from cycle T+NBYTE+1.
//     Back-to-back throughput is one op per NBYTE+2 cycles.
//   Byte-adder arithmetic: per digit, s=a+b+c (5 bits). If s>9, digit=(s+6)[3:0]
//     and carry=1; else digit=s, carry=0. Digit 1 takes its carry from digit 0.
//   Operands are captured at accept. Changes to in_a/in_b/in_cin after accept
//     have no effect.
//   Invalid digits do not stall or abort the operation. Computation still runs
//     the full NBYTE cycles, and out_err=1 accompanies the result.
//   Output registers (out_sum, out_cout, out_err) update only on the RUN->DONE
//     transition and hold through IDLE until the next completion. out_valid
//     alone qualifies them.
//   in_valid while not IDLE is ignored; the source must hold it until in_ready.
//   Asynchronous reset mid-RUN or mid-DONE aborts immediately to reset values.
//     No partial result is ever flagged valid.
//   NBYTE=1 is legal: RUN lasts one cycle.
// TESTING (NDIG=8, values hex-packed BCD)
//   A=12345678 B=87654321 cin=0 -> out_sum=99999999 cout=0 err=0; out_valid
//     rises exactly 5 cycles after the accept edge.
//   A=99999999 B=00000001 cin=0 -> out_sum=00000000 cout=1 (carry ripples
//     through all 4 bytes).
//   A=00000000 B=00000000 cin=1 -> out_sum=00000001 cout=0. Then
//     A=49999999 B=50000000 cin=1 -> out_sum=00000000 cout=1.
//   A=0000000A B=00000001 -> out_err=1, out_valid after the same 5 cycles.
//     A following op of 11111111+22222222 -> 33333333 err=0.
//   Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, out_sum,
//     out_cout, out_err stable; in_ready=0 and in_valid pulses ignored. On
//     out_ready=1, in_ready=1 next cycle.
//   Assert rst_n=0 on cycle 2 of RUN -> all outputs equal reset values
//     immediately. The next op after reset computes correctly with no stale carry.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer.
// One 2-digit adder stage is reused across NBYTE cycles, LSB byte first.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NDIG-1:0] in_a,
  input  logic [4*NDIG-1:0] in_b,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*NDIG-1:0] out_sum,
  output logic            out_cout,
  output logic            out_err,
  output logic            busy
);

  localparam int NBYTE = NDIG / 2;
  localparam int W     = 4 * NDIG;
  localparam int IW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_nx;
  logic          carry_q;
  logic          err_q;
  logic [IW-1:0] idx_q;
  logic          last;
  logic          in_err;
  logic [7:0]    byte_sum;
  logic          byte_cout;

  // Two decimal digits with ripple carry; out-of-range digits
  // still follow the same +6 correction rule.
  function automatic logic [8:0] add_byte(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       c
  );
    logic [4:0] s0;
    logic [4:0] s1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       c0;
    logic       c1;
    s0 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c};
    if (s0 > 5'd9) begin
      d0 = s0[3:0] + 4'd6;
      c0 = 1'b1;
    end else begin
      d0 = s0[3:0];
      c0 = 1'b0;
    end
    s1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c0};
    if (s1 > 5'd9) begin
      d1 = s1[3:0] + 4'd6;
      c1 = 1'b1;
    end else begin
      d1 = s1[3:0];
      c1 = 1'b0;
    end
    return {c1, d1, d0};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last      = (idx_q == LAST);

  // Flag any non-decimal nibble in the incoming operands.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (in_a[4*i +: 4] > 4'd9 || in_b[4*i +: 4] > 4'd9) begin
        in_err = 1'b1;
      end
    end
  end

  // Current byte through the shared adder, merged into the result.
  always_comb begin
    {byte_cout, byte_sum} = add_byte(a_q[{idx_q, 3'b000} +: 8],
                                     b_q[{idx_q, 3'b000} +: 8],
                                     carry_q);
    res_nx = res_q;
    res_nx[{idx_q, 3'b000} +: 8] = byte_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, byte stepping and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_err  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      err_q   <= in_err;
      idx_q   <= '0;
      res_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_nx;
      carry_q <= byte_cout;
      if (last) begin
        out_sum  <= res_nx;
        out_cout <= byte_cout;
        out_err  <= err_q;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
